// File: rtl/sensor_conditioner.sv
// Sensor front-end: 2-flop synchronisers and debouncers for four binary sensors
// (fire alarm asserts immediately), plus a 4-tap running-average temperature filter.
module sensor_conditioner #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 3,
  parameter int TEMP_W    = 7,
  parameter int TEMP_MAX  = 119
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              raw_fd,
  input  logic              raw_rd,
  input  logic              raw_w,
  input  logic              raw_fa,
  input  logic [TEMP_W-1:0] temp_raw,
  input  logic              temp_valid,
  output logic              SFD,
  output logic              SRD,
  output logic              SW,
  output logic              SFA,
  output logic [TEMP_W-1:0] ST,
  output logic              st_update,
  output logic              temp_fault
);

  localparam int N_CH  = 4;
  localparam int CH_FA = 3;
  localparam int SUM_W = TEMP_W + 2;

  // ---------------------------------------------------------------------------
  // Binary sensors
  // ---------------------------------------------------------------------------
  logic [N_CH-1:0]  raw;
  logic [N_CH-1:0]  s1;
  logic [N_CH-1:0]  s2;
  logic [N_CH-1:0]  db;
  logic [CNT_W-1:0] cnt [N_CH];

  assign raw = {raw_fa, raw_w, raw_rd, raw_fd};

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours (s2 <= s1 really delays).
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1 <= '0;
      s2 <= '0;
      db <= '0;
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < N_CH; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (i == CH_FA && s2[i]) begin
          // Fire alarm assertion is safety-critical: no debounce delay.
          db[i]  <= 1'b1;
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign {SFA, SW, SRD, SFD} = db;

  // ---------------------------------------------------------------------------
  // Temperature filter
  // ---------------------------------------------------------------------------
  logic [TEMP_W-1:0] taps [4];
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  sum_n;
  logic              primed;
  logic              good;
  logic              bad;

  assign good  = temp_valid && (temp_raw <= TEMP_W'(TEMP_MAX));
  assign bad   = temp_valid && !good;
  assign sum_n = sum - SUM_W'(taps[3]) + SUM_W'(temp_raw);

  // NOTE: the tap array is reset because a re-primed filter must never see
  // stale samples; it is only four registers, not a RAM.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < 4; i++) taps[i] <= '0;
      sum        <= '0;
      primed     <= 1'b0;
      ST         <= '0;
      st_update  <= 1'b0;
      temp_fault <= 1'b0;
    end else begin
      st_update <= good;
      if (bad) begin
        temp_fault <= 1'b1;
      end else if (good) begin
        temp_fault <= 1'b0;
      end
      if (good) begin
        if (!primed) begin
          // First sample fills the window so the average starts at that value.
          for (int i = 0; i < 4; i++) taps[i] <= temp_raw;
          sum    <= {temp_raw, 2'b00};
          ST     <= temp_raw;
          primed <= 1'b1;
        end else begin
          taps[0] <= temp_raw;
          taps[1] <= taps[0];
          taps[2] <= taps[1];
          taps[3] <= taps[2];
          sum     <= sum_n;
          ST      <= sum_n[SUM_W-1:2];
        end
      end
    end
  end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed self-checking bench for sensor_conditioner: debounce timing, fire-alarm
// fast path, temperature averaging, fault handling and asynchronous reset.
module tb_sensor_conditioner;

  logic       Clk;
  logic       Rst_n;
  logic       raw_fd;
  logic       raw_rd;
  logic       raw_w;
  logic       raw_fa;
  logic [6:0] temp_raw;
  logic       temp_valid;
  logic       SFD;
  logic       SRD;
  logic       SW;
  logic       SFA;
  logic [6:0] ST;
  logic       st_update;
  logic       temp_fault;

  int vectors     = 0;
  int miscompares = 0;

  sensor_conditioner dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .raw_fd     (raw_fd),
    .raw_rd     (raw_rd),
    .raw_w      (raw_w),
    .raw_fa     (raw_fa),
    .temp_raw   (temp_raw),
    .temp_valid (temp_valid),
    .SFD        (SFD),
    .SRD        (SRD),
    .SW         (SW),
    .SFA        (SFA),
    .ST         (ST),
    .st_update  (st_update),
    .temp_fault (temp_fault)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sfd"}, 8'(SFD), 8'd0);
    check({tag, "_srd"}, 8'(SRD), 8'd0);
    check({tag, "_sw"},  8'(SW),  8'd0);
    check({tag, "_sfa"}, 8'(SFA), 8'd0);
    check({tag, "_st"},  8'(ST),  8'd0);
    check({tag, "_upd"}, 8'(st_update),  8'd0);
    check({tag, "_flt"}, 8'(temp_fault), 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ramp_st [8];
    logic [6:0] avg_st  [4];
    ramp_st = '{7'd10, 7'd10, 7'd10, 7'd11, 7'd12, 7'd13, 7'd14, 7'd15};
    avg_st  = '{7'd26, 7'd27, 7'd28, 7'd29};

    Rst_n = 1'b0; raw_fd = 1'b0; raw_rd = 1'b0; raw_w = 1'b0; raw_fa = 1'b0;
    temp_raw = '0; temp_valid = 1'b0;
    #12;
    check_all_zero("reset");
    tick();
    Rst_n = 1'b1;
    tick();

    // Test 1: front-door bounce 1,0,1 then hold.
    raw_fd = 1'b1; tick(); check("t1_bounce_a", 8'(SFD), 8'd0);
    raw_fd = 1'b0; tick(); check("t1_bounce_b", 8'(SFD), 8'd0);
    raw_fd = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("t1_hold", 8'(SFD), 8'd0);
    end
    tick(); check("t1_rise_edge6", 8'(SFD), 8'd1);

    // Test 2: fire alarm fast rise, debounced fall, blip rejection.
    raw_fa = 1'b1;
    tick(); tick(); check("t2_fa_edge2", 8'(SFA), 8'd0);
    tick();         check("t2_fa_edge3", 8'(SFA), 8'd1);
    raw_fa = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("t2_fa_fall_hold", 8'(SFA), 8'd1);
    end
    tick(); check("t2_fa_fall_edge6", 8'(SFA), 8'd0);
    raw_fa = 1'b1;
    tick(); tick(); tick(); check("t2_fa_reassert", 8'(SFA), 8'd1);
    raw_fa = 1'b0; tick(); tick();
    raw_fa = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t2_fa_blip", 8'(SFA), 8'd1);
    end

    // Test 3: prime with 25, then four 29s.
    temp_valid = 1'b1; temp_raw = 7'd25;
    tick();
    check("t3_prime_st",  8'(ST), 8'd25);
    check("t3_prime_upd", 8'(st_update), 8'd1);
    temp_raw = 7'd29;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t3_avg_st",  8'(ST), 8'(avg_st[k]));
      check("t3_avg_upd", 8'(st_update), 8'd1);
    end
    temp_valid = 1'b0;
    tick();
    check("t3_idle_upd", 8'(st_update), 8'd0);
    check("t3_idle_st",  8'(ST), 8'd29);

    // Test 4: out-of-range sample dropped, then recovery.
    temp_valid = 1'b1; temp_raw = 7'd127;
    tick();
    check("t4_fault_st",  8'(ST), 8'd29);
    check("t4_fault_flt", 8'(temp_fault), 8'd1);
    check("t4_fault_upd", 8'(st_update), 8'd0);
    temp_raw = 7'd29;
    tick();
    check("t4_good_flt", 8'(temp_fault), 8'd0);
    check("t4_good_st",  8'(ST), 8'd29);
    check("t4_good_upd", 8'(st_update), 8'd1);
    temp_valid = 1'b0;

    // Test 5: async reset mid-debounce (SRD counter at 2) and mid-average.
    raw_rd = 1'b1;
    tick(); tick(); tick();
    temp_valid = 1'b1; temp_raw = 7'd101;
    tick();
    check("t5_pre_st",  8'(ST), 8'd47);
    check("t5_pre_upd", 8'(st_update), 8'd1);
    check("t5_pre_srd", 8'(SRD), 8'd0);
    temp_valid = 1'b0;
    #2 Rst_n = 1'b0;
    #1 check_all_zero("t5_async");
    #1 Rst_n = 1'b1;
    temp_valid = 1'b1; temp_raw = 7'd60;
    tick();
    check("t5_reprime_st",  8'(ST), 8'd60);
    check("t5_reprime_upd", 8'(st_update), 8'd1);
    temp_valid = 1'b0;
    tick(); check("t5_sfa_edge2", 8'(SFA), 8'd0);
    tick(); check("t5_sfa_edge3", 8'(SFA), 8'd1);
    tick(); tick();
    check("t5_srd_edge5", 8'(SRD), 8'd0);
    check("t5_sfd_edge5", 8'(SFD), 8'd0);
    tick();
    check("t5_srd_edge6", 8'(SRD), 8'd1);
    check("t5_sfd_edge6", 8'(SFD), 8'd1);

    // Test 6: fresh reset, ramp 10..17 every cycle with raw_w bouncing 1,0,1.
    Rst_n = 1'b0;
    #1 Rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      temp_valid = 1'b1;
      temp_raw   = 7'(10 + k);
      raw_w      = (k == 1) ? 1'b0 : 1'b1;
      tick();
      check("t6_ramp_st",  8'(ST), 8'(ramp_st[k]));
      check("t6_ramp_upd", 8'(st_update), 8'd1);
      check("t6_ramp_sw",  8'(SW), (k == 7) ? 8'd1 : 8'd0);
    end
    temp_valid = 1'b0;
    tick();
    check("t6_end_upd", 8'(st_update), 8'd0);
    check("t6_end_sw",  8'(SW), 8'd1);
    check("t6_end_st",  8'(ST), 8'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
